gomoku_turn_ctrl: RTL

- Game-flow controller that drives the move-load interface of the 7x7 board (go, x, y, color) and consumes the board's 2-bit win state.
- Turns single-cycle player button pulses into a cursor, rejects moves onto occupied cells, alternates black/white turns, waits for the board's win result after each move, and latches the winner or a draw.
- Sits between the input debouncers/edge detectors and the board instance in the top level.

---
 rtl/gomoku_turn_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/gomoku_turn_ctrl.sv
// Turn controller for a 7x7 gomoku board: cursor, placement legality, move issue and result latch.
// Fully registered outputs; buttons are ignored while a move is in flight and after the game ends.
module gomoku_turn_ctrl #(
    parameter int N           = 7,
    parameter int CW          = 3,
    parameter int RESULT_WAIT = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_place,
    input  logic [1:0]    board_state,
    output logic          go,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          color,
    output logic [CW-1:0] cursor_x,
    output logic [CW-1:0] cursor_y,
    output logic          turn,
    output logic          busy,
    output logic          illegal,
    output logic [5:0]    move_count,
    output logic          game_over,
    output logic [1:0]    winner
);

    localparam int CELLS = N * N;
    localparam int IW    = $clog2(CELLS);
    localparam int WW    = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;
    localparam logic [CW-1:0] MAXC = CW'(N - 1);
    localparam logic [CW-1:0] MIDC = CW'(N / 2);

    typedef enum logic [2:0] {
        S_PLAY,
        S_ISSUE,
        S_WAIT,
        S_EVAL,
        S_OVER
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [CW-1:0]   x_q, x_d, y_q, y_d;
    logic            color_q, color_d, turn_q, turn_d;
    logic            go_q, go_d, busy_q, busy_d, illegal_q, illegal_d;
    logic [5:0]      mcnt_q, mcnt_d;
    logic            over_q, over_d;
    logic [1:0]      winner_q, winner_d;
    logic [CELLS-1:0] occ_q, occ_d;
    logic [IW-1:0]   cur_idx;

    assign cur_idx = IW'(cur_y_q) * IW'(N) + IW'(cur_x_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_PLAY;
            cnt_q     <= '0;
            cur_x_q   <= MIDC;
            cur_y_q   <= MIDC;
            x_q       <= '0;
            y_q       <= '0;
            color_q   <= 1'b0;
            turn_q    <= 1'b0;
            go_q      <= 1'b0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
            mcnt_q    <= '0;
            over_q    <= 1'b0;
            winner_q  <= 2'd0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            x_q       <= x_d;
            y_q       <= y_d;
            color_q   <= color_d;
            turn_q    <= turn_d;
            go_q      <= go_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
            mcnt_q    <= mcnt_d;
            over_q    <= over_d;
            winner_q  <= winner_d;
            occ_q     <= occ_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        x_d       = x_q;
        y_d       = y_q;
        color_d   = color_q;
        turn_d    = turn_q;
        go_d      = 1'b0;
        busy_d    = busy_q;
        illegal_d = 1'b0;
        mcnt_d    = mcnt_q;
        over_d    = over_q;
        winner_d  = winner_q;
        occ_d     = occ_q;

        case (state_q)
            S_PLAY: begin
                if (btn_place) begin
                    if (occ_q[cur_idx]) begin
                        illegal_d = 1'b1;
                    end else begin
                        x_d            = cur_x_q;
                        y_d            = cur_y_q;
                        color_d        = turn_q;
                        occ_d[cur_idx] = 1'b1;
                        mcnt_d         = mcnt_q + 6'd1;
                        go_d           = 1'b1;
                        busy_d         = 1'b1;
                        state_d        = S_ISSUE;
                    end
                end else begin
                    // Opposing pulses cancel; each axis saturates independently.
                    if (btn_up && !btn_down && cur_y_q != '0)
                        cur_y_d = cur_y_q - 1'b1;
                    else if (btn_down && !btn_up && cur_y_q != MAXC)
                        cur_y_d = cur_y_q + 1'b1;
                    if (btn_left && !btn_right && cur_x_q != '0)
                        cur_x_d = cur_x_q - 1'b1;
                    else if (btn_right && !btn_left && cur_x_q != MAXC)
                        cur_x_d = cur_x_q + 1'b1;
                end
            end
            S_ISSUE: begin
                cnt_d   = WW'(RESULT_WAIT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0)
                    state_d = S_EVAL;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            S_EVAL: begin
                // busy spans ISSUE, WAIT and EVAL: every cycle a move is unresolved.
                busy_d = 1'b0;
                if (board_state == 2'd1 || board_state == 2'd2) begin
                    winner_d = board_state;
                    over_d   = 1'b1;
                    state_d  = S_OVER;
                end else if (mcnt_q == 6'(CELLS)) begin
                    winner_d = 2'd3;
                    over_d   = 1'b1;
                    state_d  = S_OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = S_PLAY;
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_PLAY;
            end
        endcase
    end

    assign go         = go_q;
    assign x          = x_q;
    assign y          = y_q;
    assign color      = color_q;
    assign cursor_x   = cur_x_q;
    assign cursor_y   = cur_y_q;
    assign turn       = turn_q;
    assign busy       = busy_q;
    assign illegal    = illegal_q;
    assign move_count = mcnt_q;
    assign game_over  = over_q;
    assign winner     = winner_q;

endmodule
